// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Receive-side framing stage between the UART receiver and the two matrix
// memories. Recognises a load frame on the incoming byte stream:
//
//   SYNC, A[0..N*N-1], B[0..N*N-1], checksum
//
// and writes A and B row-major into their memories. The checksum is the
// modulo-256 sum of the matrix bytes only. On the checksum byte the block
// pulses load_done (match) or load_err (mismatch) and returns to IDLE.
//
// Parameters
//   N       matrix dimension (N*N elements per matrix)
//   DATA_W  element width, equal to the UART byte width
//   ADDR_W  memory address width, N*N <= 2**ADDR_W
//   SYNC    frame header byte
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   mult_busy  in   multiplier / result transmission in progress
//   a_we       out  write enable, matrix A memory (one cycle)
//   b_we       out  write enable, matrix B memory (one cycle)
//   addr       out  write address shared by both memories
//   wdata      out  write data shared by both memories
//   busy       out  high whenever a frame is in progress
//   load_done  out  one-cycle pulse, frame accepted
//   load_err   out  one-cycle pulse, checksum mismatch
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int              N      = 3,
  parameter int              DATA_W = 8,
  parameter int              ADDR_W = 4,
  parameter logic [DATA_W-1:0] SYNC = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              mult_busy,
  output logic              a_we,
  output logic              b_we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  // Index of the last element of a matrix; cnt wraps to 0 after it.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] acc;

  // Single registered process: every output is a flop, and every state
  // change is qualified by rx_valid so idle cycles leave the frame untouched.
  // NOTE: non-blocking assignments throughout so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_we      <= 1'b0;
      b_we      <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless re-armed below.
      a_we      <= 1'b0;
      b_we      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;

      if (rx_valid) begin
        case (state)
          IDLE: begin
            // Only an unblocked SYNC opens a frame; everything else is dropped.
            if (rx_data == SYNC && !mult_busy) begin
              state <= LOAD_A;
              cnt   <= '0;
              acc   <= '0;
              busy  <= 1'b1;
            end
          end

          LOAD_A: begin
            // SYNC is not escaped inside a frame: every byte here is data.
            a_we  <= 1'b1;
            addr  <= cnt;
            wdata <= rx_data;
            acc   <= acc + rx_data;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          LOAD_B: begin
            b_we  <= 1'b1;
            addr  <= cnt;
            wdata <= rx_data;
            acc   <= acc + rx_data;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          CHECK: begin
            // busy drops in the same cycle as the verdict pulse, so a SYNC on
            // the very next byte can start the following frame.
            if (rx_data == acc) begin
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The strobes are mutually exclusive by construction: one byte produces at
  // most one action.
  a_exclusive: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({a_we, b_we, load_done, load_err}));

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
//
// Self-checking bench for matrix_loader (N=3). Stimulus tasks push the
// expected write / verdict events into a scoreboard queue as each byte is
// driven; a monitor pops and compares them whenever the DUT raises a strobe.
// -----------------------------------------------------------------------------
module tb_matrix_loader;

  localparam int N  = 3;
  localparam int NN = N * N;

  localparam int K_A    = 0;
  localparam int K_B    = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       mult_busy;
  logic       a_we;
  logic       b_we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       load_done;
  logic       load_err;

  matrix_loader #(
    .N      (N),
    .DATA_W (8),
    .ADDR_W (4),
    .SYNC   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mult_busy (mult_busy),
    .a_we      (a_we),
    .b_we      (b_we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [7:0] frame_a [NN];
  logic [7:0] frame_b [NN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic exp_t mk(input int kind, input int a, input int d);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // Drive one byte; called at a negedge, returns at the next negedge. Back-to-
  // back calls keep rx_valid high continuously.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full frame from frame_a/frame_b. bad_csum corrupts the checksum by +1.
  // mb_mid raises mult_busy for the body of the frame, which must be ignored.
  task automatic send_frame(input bit bad_csum, input bit mb_mid, input string tag);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < NN; i++) sum = sum + frame_a[i] + frame_b[i];
    send_byte(8'hA5);
    check({tag, "_busy_rise"}, busy, 1);
    if (mb_mid) mult_busy = 1'b1;
    for (int i = 0; i < NN; i++) begin
      sb.push_back(mk(K_A, i, frame_a[i]));
      send_byte(frame_a[i]);
    end
    for (int i = 0; i < NN; i++) begin
      sb.push_back(mk(K_B, i, frame_b[i]));
      send_byte(frame_b[i]);
    end
    mult_busy = 1'b0;
    sb.push_back(mk(bad_csum ? K_ERR : K_DONE, 0, 0));
    send_byte(bad_csum ? sum + 8'd1 : sum);
    check({tag, "_busy_fall"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_we"},      a_we, 0);
    check({tag, "_b_we"},      b_we, 0);
    check({tag, "_addr"},      addr, 0);
    check({tag, "_wdata"},     wdata, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_err"},  load_err, 0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (a_we || b_we || load_done || load_err)) begin
      int kind;
      exp_t e;
      check("exclusive", $countones({a_we, b_we, load_done, load_err}), 1);
      kind = a_we ? K_A : b_we ? K_B : load_done ? K_DONE : K_ERR;
      if (kind == K_DONE) done_cnt++;
      if (kind == K_ERR)  err_cnt++;
      if (sb.size() == 0) begin
        check("spurious_evt", {a_we, b_we, load_done, load_err}, 0);
      end else begin
        e = sb.pop_front();
        check("evt_kind", kind, e.kind);
        if (kind == K_A || kind == K_B) begin
          check("evt_addr",  addr,  e.addr);
          check("evt_wdata", wdata, e.data);
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    mult_busy = 1'b0;
    idle(2);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(2);

    // IDLE filtering: non-SYNC bytes are dropped.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    idle(2);
    check("filter_busy", busy, 0);

    // SYNC blocked by mult_busy; the following byte must not be written.
    mult_busy = 1'b1;
    send_byte(8'hA5);
    check("blocked_busy", busy, 0);
    mult_busy = 1'b0;
    send_byte(8'h01);
    idle(2);
    check("blocked_busy2", busy, 0);

    // Good frame: A=1..9, B=9..1, checksum 0x5A.
    for (int i = 0; i < NN; i++) begin
      frame_a[i] = 8'(i + 1);
      frame_b[i] = 8'(NN - i);
    end
    send_frame(1'b0, 1'b0, "good");
    idle(2);
    check("good_done_cnt", done_cnt, 1);

    // Same frame with checksum 0x5B; mult_busy mid-frame has no effect.
    send_frame(1'b1, 1'b1, "bad");
    idle(2);
    check("bad_err_cnt",  err_cnt, 1);
    check("bad_done_cnt", done_cnt, 1);

    // Mid-frame reset after 5 A bytes.
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(K_A, i, 8'h20 + 8'(i)));
      send_byte(8'h20 + 8'(i));
    end
    idle(1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fresh frame after reset must load from address 0.
    for (int i = 0; i < NN; i++) begin
      frame_a[i] = 8'h10 + 8'(i);
      frame_b[i] = 8'hF0 + 8'(i);
    end
    send_frame(1'b0, 1'b0, "postrst");
    idle(2);
    check("postrst_done_cnt", done_cnt, 2);

    // Back-to-back: two frames with rx_valid continuously high; the second
    // carries SYNC value A5 as element A[4].
    for (int i = 0; i < NN; i++) begin
      frame_a[i] = 8'h80 + 8'(i * 7);
      frame_b[i] = 8'(i * 31);
    end
    send_frame(1'b0, 1'b0, "b2b1");
    frame_a[4] = 8'hA5;
    send_frame(1'b0, 1'b0, "b2b2");
    idle(3);
    check("b2b_done_cnt", done_cnt, 4);
    check("final_err_cnt", err_cnt, 1);
    check("final_sb_empty", sb.size(), 0);
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net: the directed sequence is bounded, so this never fires unless
  // the simulator stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Receive-side framing stage between the UART receiver and the two matrix memories. Consumes the byte stream (`rx_data`/`rx_valid`) and recognises a load frame: sync byte, matrix A, matrix B, checksum. Writes A and B row-major into their memories and signals the control unit to start the multiplier (`load_done`) or to discard the frame (`load_err`).

## Interface
- `N`, 3: matrix dimension; each matrix holds N*N elements.
- `DATA_W`, 8: element width; equals the UART byte width.
- `ADDR_W`, 4: memory address width; N*N must be ≤ 2^ADDR_W.
- `SYNC`, 8'hA5: frame header byte.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `mult_busy` in 1: multiplier or result transmission in progress.
- `a_we` out 1: write enable, matrix A memory.
- `b_we` out 1: write enable, matrix B memory.
- `addr` out ADDR_W: write address, shared by both memories.
- `wdata` out DATA_W: write data, shared by both memories.
- `busy` out 1: high in any state other than IDLE.
- `load_done` out 1: one-cycle pulse, frame accepted.
- `load_err` out 1: one-cycle pulse, checksum mismatch.

## Operation
- **Frame format:** `SYNC`, then N*N A bytes (row-major, element (r,c) at address r*N+c), then N*N B bytes (same ordering), then one checksum byte.
- **Checksum:** 8-bit sum, modulo 256, of the 2*N*N matrix bytes only. Header and checksum bytes are excluded.
- **Clocking:** all state changes occur only on cycles where `rx_valid`=1.
- **IDLE:**
  - `rx_valid` with `rx_data`==`SYNC` and `mult_busy`=0 → LOAD_A. Element counter and checksum accumulator are cleared.
  - Any other byte is dropped.
  - `SYNC` while `mult_busy`=1 is dropped.
- **LOAD_A:**
  - Each byte writes A[cnt] and adds to the accumulator; cnt increments.
  - On byte N*N-1: cnt wraps to 0 → LOAD_B.
- **LOAD_B:** same as LOAD_A, writing B[cnt]. On byte N*N-1: cnt wraps to 0 → CHECK.
- **CHECK:**
  - Next byte is compared to the accumulator.
  - Equal → `load_done` pulse. Not equal → `load_err` pulse.
  - Both cases → IDLE.
- **No escaping:** a `SYNC` value inside LOAD_A, LOAD_B or CHECK is treated as data.
- **No rollback:** memory contents written by a failed frame stay in place. The control unit must not start the multiplier on `load_err`.
- **`mult_busy` mid-frame:** no effect once the frame has started. The frame completes normally.
- **Timeout:** none. A truncated frame waits indefinitely until `rst`.

## Timing
- **Reset values (`rst`=0):** state IDLE; cnt=0; accumulator=0; `a_we`=`b_we`=0; `addr`=0; `wdata`=0; `busy`=0; `load_done`=`load_err`=0.
- **Mid-frame reset:** reset asserted during a frame returns the block to IDLE immediately. Partial memory writes are not undone.
- **Registered outputs:** all outputs are registered.
- **Write latency:** `a_we`/`b_we` assert the cycle after the `rx_valid` that carries the data byte. `addr` and `wdata` are valid in that same cycle. Write enables are high for exactly one cycle.
- **Completion latency:** `load_done`/`load_err` assert the cycle after the checksum byte's `rx_valid`.
- **`busy` timing:**
  - Rises the cycle after the accepted `SYNC`.
  - Falls in the same cycle `load_done`/`load_err` pulses.
- **Back-to-back input:** `rx_valid` may be high on consecutive cycles. Every byte is consumed and none is dropped.
- **Back-to-back frames:** a `SYNC` arriving the cycle after the checksum is accepted, provided `mult_busy`=0.
- **Output exclusivity:** at most one of `a_we`, `b_we`, `load_done`, `load_err` is high in any cycle.

## Test plan
- **Good frame (N=3):** A5, 01..09, 09..01, 5A → A[0..8]=1..9 and B[0..8]=9..1, 18 single-cycle write strobes, then `load_done` pulse and `busy` low.
- **Bad checksum:** same frame ending in 5B → memories written as above, `load_err` pulse, `load_done` never asserted.
- **IDLE filtering:**
  - Bytes 00, FF, 3C sent in IDLE → no writes, `busy` stays 0.
  - A5 sent with `mult_busy`=1 → dropped. The following 01 produces no write.
- **Mid-frame reset:** `rst` pulsed low after 5 A bytes → all outputs at reset values. A new complete frame then loads correctly from address 0.
- **Back-to-back timing:** `rx_valid` held high for 20 consecutive cycles carrying a full frame, then a second frame's A5 on the next cycle → both frames load; `load_done` pulses twice.
- **Sync value as data:** A element value A5 within LOAD_A → written as data to the correct address; frame alignment is unaffected.
